// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared ISA field layout, opcode/aluop constants and the mult/div FSM state type
// used by the hazard and stall controller.
package proc_isa_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;
    localparam int ALU_HI = 6;
    localparam int ALU_LO = 2;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_JR   = 5'b00100;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_BUSY  = 2'd1,
        MD_DRAIN = 2'd2
    } md_state_e;

    function automatic logic [4:0] f_opcode(input logic [31:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[RD_HI:RD_LO];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[RT_HI:RT_LO];
    endfunction

    function automatic logic [4:0] f_aluop(input logic [31:0] ir);
        return ir[ALU_HI:ALU_LO];
    endfunction

    function automatic logic is_mult(input logic [31:0] ir);
        return (f_opcode(ir) == OP_R) && (f_aluop(ir) == ALU_MULT);
    endfunction

    function automatic logic is_div(input logic [31:0] ir);
        return (f_opcode(ir) == OP_R) && (f_aluop(ir) == ALU_DIV);
    endfunction

    function automatic logic is_lw(input logic [31:0] ir);
        return f_opcode(ir) == OP_LW;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of the hazard/stall controller: instruction words in,
// stall/bubble/mult-div control and performance counters out.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);

    logic [31:0]      fd_ir;
    logic [31:0]      dx_ir;
    logic             md_ready;
    logic             cnt_clear;
    logic             stall;
    logic             ld_bubble;
    logic             md_start_mult;
    logic             md_start_div;
    logic             md_busy;
    logic             md_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] md_ops;

    modport master (
        output fd_ir, dx_ir, md_ready, cnt_clear,
        input  stall, ld_bubble, md_start_mult, md_start_div, md_busy, md_error,
        input  stall_cycles, md_ops
    );

    modport slave (
        input  fd_ir, dx_ir, md_ready, cnt_clear,
        output stall, ld_bubble, md_start_mult, md_start_div, md_busy, md_error,
        output stall_cycles, md_ops
    );

endinterface

// File: rtl/hazard_stall_ctrl_src_reg_decode.sv
// Source-register decode of one instruction: which register fields it reads,
// with register 0 already masked out so a valid bit alone means "can hazard".
module src_reg_decode
    import proc_isa_pkg::*;
#(
    parameter int STORE_DATA_BYPASS = 1
) (
    input  logic [31:0] ir_i,
    output logic        src_a_vld_o,
    output logic [4:0]  src_a_o,
    output logic        src_b_vld_o,
    output logic [4:0]  src_b_o,
    output logic        src_d_vld_o,
    output logic [4:0]  src_d_o
);

    logic [4:0] opc_s;
    logic [4:0] rd_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic       use_a_s;
    logic       use_b_s;
    logic       use_d_s;
    logic [4:0] addr_a_s;
    logic [4:0] addr_b_s;

    assign opc_s = f_opcode(ir_i);
    assign rd_s  = f_rd(ir_i);
    assign rs_s  = f_rs(ir_i);
    assign rt_s  = f_rt(ir_i);

    // Per-opcode read ports; branches and jr read the rd field as a source.
    always_comb begin
        use_a_s  = 1'b0;
        use_b_s  = 1'b0;
        use_d_s  = 1'b0;
        addr_a_s = rs_s;
        addr_b_s = rt_s;
        case (opc_s)
            OP_R: begin
                use_a_s = 1'b1;
                use_b_s = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                use_a_s = 1'b1;
            end
            OP_SW: begin
                use_a_s = 1'b1;
                use_d_s = (STORE_DATA_BYPASS == 0);
            end
            OP_BNE, OP_BLT: begin
                use_a_s  = 1'b1;
                use_b_s  = 1'b1;
                addr_b_s = rd_s;
            end
            OP_JR: begin
                use_a_s  = 1'b1;
                addr_a_s = rd_s;
            end
            default: begin
                use_a_s = 1'b0;
                use_b_s = 1'b0;
                use_d_s = 1'b0;
            end
        endcase
    end

    assign src_a_o     = addr_a_s;
    assign src_b_o     = addr_b_s;
    assign src_d_o     = rd_s;
    assign src_a_vld_o = use_a_s && (addr_a_s != 5'd0);
    assign src_b_vld_o = use_b_s && (addr_b_s != 5'd0);
    assign src_d_vld_o = use_d_s && (rd_s != 5'd0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detection and mult/div sequencing between the F/D and D/X
// latches, with saturating stall-cycle and completed-op counters.
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT        = 64,
    parameter int CNT_W             = 32,
    parameter int STORE_DATA_BYPASS = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    hazard_stall_ctrl_if.slave bus
);

    import proc_isa_pkg::*;

    localparam int               TMR_W   = $clog2(MD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MD_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             md_error_q;
    logic             md_error_d;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;
    logic [CNT_W-1:0] md_ops_q;
    logic [CNT_W-1:0] md_ops_d;

    logic             src_a_vld_s;
    logic [4:0]       src_a_s;
    logic             src_b_vld_s;
    logic [4:0]       src_b_s;
    logic             src_d_vld_s;
    logic [4:0]       src_d_s;

    logic             dx_lw_s;
    logic             dx_mult_s;
    logic             dx_div_s;
    logic [4:0]       dx_rd_s;
    logic             load_use_s;
    logic             start_mult_s;
    logic             start_div_s;
    logic             md_stall_s;
    logic             md_done_s;
    logic             md_abort_s;
    logic             stall_s;

    src_reg_decode #(
        .STORE_DATA_BYPASS (STORE_DATA_BYPASS)
    ) u_fd_src (
        .ir_i        (bus.fd_ir),
        .src_a_vld_o (src_a_vld_s),
        .src_a_o     (src_a_s),
        .src_b_vld_o (src_b_vld_s),
        .src_b_o     (src_b_s),
        .src_d_vld_o (src_d_vld_s),
        .src_d_o     (src_d_s)
    );

    assign dx_lw_s   = is_lw(bus.dx_ir);
    assign dx_mult_s = is_mult(bus.dx_ir);
    assign dx_div_s  = is_div(bus.dx_ir);
    assign dx_rd_s   = f_rd(bus.dx_ir);

    // Load-use: an in-flight lw writing a register the F/D instruction reads.
    always_comb begin
        load_use_s = 1'b0;
        if (dx_lw_s && (dx_rd_s != 5'd0)) begin
            load_use_s = (src_a_vld_s && (src_a_s == dx_rd_s))
                      || (src_b_vld_s && (src_b_s == dx_rd_s))
                      || (src_d_vld_s && (src_d_s == dx_rd_s));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Mult/div sequencing: start pulse, bounded wait for ready, one-cycle drain after abort.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        start_mult_s = 1'b0;
        start_div_s  = 1'b0;
        md_stall_s   = 1'b0;
        md_done_s    = 1'b0;
        md_abort_s   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (dx_mult_s || dx_div_s) begin
                    start_mult_s = dx_mult_s;
                    start_div_s  = dx_div_s;
                    md_stall_s   = 1'b1;
                    timer_d      = TMR_ONE;
                    state_d      = MD_BUSY;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                // A ready arriving on the timeout cycle still completes the op.
                if (bus.md_ready) begin
                    md_done_s = 1'b1;
                    timer_d   = '0;
                    state_d   = MD_IDLE;
                end else if (timer_q == TMR_MAX) begin
                    md_abort_s = 1'b1;
                    timer_d    = '0;
                    state_d    = MD_DRAIN;
                end else begin
                    md_stall_s = 1'b1;
                    timer_d    = timer_q + TMR_ONE;
                end
            end
            MD_DRAIN: begin
                timer_d = '0;
                state_d = MD_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = MD_IDLE;
            end
        endcase
    end

    assign stall_s    = load_use_s | md_stall_s;
    assign md_error_d = md_error_q | md_abort_s;

    // Saturating counters; a clear in the same cycle as an event wins.
    always_comb begin
        if (bus.cnt_clear) begin
            stall_cycles_d = '0;
            md_ops_d       = '0;
        end else begin
            if (stall_s && (stall_cycles_q != CNT_MAX)) begin
                stall_cycles_d = stall_cycles_q + CNT_ONE;
            end else begin
                stall_cycles_d = stall_cycles_q;
            end
            if (md_done_s && (md_ops_q != CNT_MAX)) begin
                md_ops_d = md_ops_q + CNT_ONE;
            end else begin
                md_ops_d = md_ops_q;
            end
        end
    end

    // State, timer, sticky error and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= MD_IDLE;
            timer_q        <= '0;
            md_error_q     <= 1'b0;
            stall_cycles_q <= '0;
            md_ops_q       <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            md_error_q     <= md_error_d;
            stall_cycles_q <= stall_cycles_d;
            md_ops_q       <= md_ops_d;
        end
    end

    assign bus.stall         = stall_s;
    assign bus.ld_bubble     = load_use_s;
    assign bus.md_start_mult = start_mult_s;
    assign bus.md_start_div  = start_div_s;
    assign bus.md_busy       = (state_q == MD_BUSY);
    assign bus.md_error      = md_error_q;
    assign bus.stall_cycles  = stall_cycles_q;
    assign bus.md_ops        = md_ops_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (default parameters, and
// bypass-off / short timeout / 4-bit counters) driven side by side.
module tb_hazard_stall_ctrl;

    localparam logic [4:0] T_R    = 5'b00000;
    localparam logic [4:0] T_ADDI = 5'b00101;
    localparam logic [4:0] T_LW   = 5'b01000;
    localparam logic [4:0] T_SW   = 5'b00111;
    localparam logic [4:0] T_BNE  = 5'b00010;
    localparam logic [4:0] T_BLT  = 5'b00110;
    localparam logic [4:0] T_JR   = 5'b00100;
    localparam logic [4:0] T_J    = 5'b00001;
    localparam logic [4:0] A_MULT = 5'b00110;
    localparam logic [4:0] A_DIV  = 5'b00111;

    typedef struct packed {
        logic stall;
        logic bub;
        logic sm;
        logic sd;
        logic busy;
        logic err;
        logic done;
    } exp_t;

    typedef struct packed {
        logic [31:0] fd;
        logic [31:0] dx;
        logic        sa;
        logic        sb;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] fd_a, dx_a, fd_b, dx_b;
    logic        rdy_a, rdy_b, clr_a, clr_b;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] m_cnt_a, m_ops_a;
    logic [3:0]  m_cnt_b, m_ops_b;
    int          n_pass;
    int          n_total;
    vec_t        vecs [16];

    hazard_stall_ctrl_if #(.CNT_W(32)) if_a ();
    hazard_stall_ctrl_if #(.CNT_W(4))  if_b ();

    assign if_a.fd_ir     = fd_a;
    assign if_a.dx_ir     = dx_a;
    assign if_a.md_ready  = rdy_a;
    assign if_a.cnt_clear = clr_a;
    assign if_b.fd_ir     = fd_b;
    assign if_b.dx_ir     = dx_b;
    assign if_b.md_ready  = rdy_b;
    assign if_b.cnt_clear = clr_b;

    hazard_stall_ctrl #(.MD_TIMEOUT(64), .CNT_W(32), .STORE_DATA_BYPASS(1)) u_a (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (if_a)
    );

    hazard_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(4), .STORE_DATA_BYPASS(0)) u_b (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] alu);
        return {T_R, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs);
        return {op, rd, rs, 17'd0};
    endfunction

    function automatic exp_t mk(input logic st, input logic bub, input logic sm, input logic sd,
                                input logic busy, input logic err, input logic done);
        exp_t e;
        e.stall = st;
        e.bub   = bub;
        e.sm    = sm;
        e.sd    = sd;
        e.busy  = busy;
        e.err   = err;
        e.done  = done;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: queue expectations, sample mid-cycle, compare, advance the counter model.
    task automatic step(input string tag, input exp_t ea, input exp_t eb);
        exp_t ga;
        exp_t gb;
        q_a.push_back(ea);
        q_b.push_back(eb);
        #4;
        if (!reset_n) begin
            m_cnt_a = '0;
            m_ops_a = '0;
            m_cnt_b = '0;
            m_ops_b = '0;
        end
        ga = q_a.pop_front();
        gb = q_b.pop_front();
        chk({tag, ".a.flags"}, 32'({if_a.stall, if_a.ld_bubble, if_a.md_start_mult,
                                    if_a.md_start_div, if_a.md_busy, if_a.md_error}),
            32'({ga.stall, ga.bub, ga.sm, ga.sd, ga.busy, ga.err}));
        chk({tag, ".b.flags"}, 32'({if_b.stall, if_b.ld_bubble, if_b.md_start_mult,
                                    if_b.md_start_div, if_b.md_busy, if_b.md_error}),
            32'({gb.stall, gb.bub, gb.sm, gb.sd, gb.busy, gb.err}));
        chk({tag, ".a.stall_cycles"}, if_a.stall_cycles, m_cnt_a);
        chk({tag, ".a.md_ops"}, if_a.md_ops, m_ops_a);
        chk({tag, ".b.stall_cycles"}, 32'(if_b.stall_cycles), 32'(m_cnt_b));
        chk({tag, ".b.md_ops"}, 32'(if_b.md_ops), 32'(m_ops_b));
        if (reset_n) begin
            if (clr_a) begin
                m_cnt_a = '0;
                m_ops_a = '0;
            end else begin
                if (ga.stall && (m_cnt_a != 32'hFFFF_FFFF)) m_cnt_a = m_cnt_a + 32'd1;
                if (ga.done && (m_ops_a != 32'hFFFF_FFFF)) m_ops_a = m_ops_a + 32'd1;
            end
            if (clr_b) begin
                m_cnt_b = '0;
                m_ops_b = '0;
            end else begin
                if (gb.stall && (m_cnt_b != 4'hF)) m_cnt_b = m_cnt_b + 4'd1;
                if (gb.done && (m_ops_b != 4'hF)) m_ops_b = m_ops_b + 4'd1;
            end
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] lw5;
        logic [31:0] nop;
        logic [31:0] mul;
        logic [31:0] dvd;
        n_pass  = 0;
        n_total = 0;
        m_cnt_a = '0;
        m_ops_a = '0;
        m_cnt_b = '0;
        m_ops_b = '0;
        lw5 = enc_i(T_LW, 5'd5, 5'd2);
        nop = 32'd0;
        mul = enc_r(5'd1, 5'd2, 5'd3, A_MULT);
        dvd = enc_r(5'd1, 5'd2, 5'd3, A_DIV);

        vecs[0]  = '{enc_r(5'd7, 5'd5, 5'd3, 5'd0), lw5, 1'b1, 1'b1};
        vecs[1]  = '{enc_r(5'd7, 5'd0, 5'd3, 5'd0), enc_i(T_LW, 5'd0, 5'd2), 1'b0, 1'b0};
        vecs[2]  = '{enc_r(5'd7, 5'd5, 5'd3, 5'd0), enc_i(T_LW, 5'd0, 5'd2), 1'b0, 1'b0};
        vecs[3]  = '{enc_i(T_SW, 5'd5, 5'd4), lw5, 1'b0, 1'b1};
        vecs[4]  = '{enc_i(T_SW, 5'd6, 5'd5), lw5, 1'b1, 1'b1};
        vecs[5]  = '{enc_r(5'd7, 5'd3, 5'd5, 5'd0), lw5, 1'b1, 1'b1};
        vecs[6]  = '{enc_i(T_ADDI, 5'd7, 5'd5), lw5, 1'b1, 1'b1};
        vecs[7]  = '{enc_i(T_ADDI, 5'd5, 5'd3), lw5, 1'b0, 1'b0};
        vecs[8]  = '{enc_i(T_BNE, 5'd5, 5'd3), lw5, 1'b1, 1'b1};
        vecs[9]  = '{enc_i(T_BLT, 5'd3, 5'd5), lw5, 1'b1, 1'b1};
        vecs[10] = '{enc_i(T_JR, 5'd5, 5'd0), lw5, 1'b1, 1'b1};
        vecs[11] = '{enc_i(T_JR, 5'd3, 5'd5), lw5, 1'b0, 1'b0};
        vecs[12] = '{enc_r(5'd7, 5'd5, 5'd3, 5'd0), enc_r(5'd5, 5'd1, 5'd2, 5'd0), 1'b0, 1'b0};
        vecs[13] = '{enc_i(T_J, 5'd5, 5'd5), lw5, 1'b0, 1'b0};
        vecs[14] = '{enc_i(T_LW, 5'd6, 5'd5), lw5, 1'b1, 1'b1};
        vecs[15] = '{enc_r(5'd7, 5'd5, 5'd3, A_MULT), lw5, 1'b1, 1'b1};

        reset_n = 1'b0;
        fd_a = nop; dx_a = nop; fd_b = nop; dx_b = nop;
        rdy_a = 1'b0; rdy_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        @(posedge clk);
        #2;
        step("reset", mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            fd_a = vecs[i].fd; dx_a = vecs[i].dx;
            fd_b = vecs[i].fd; dx_b = vecs[i].dx;
            step($sformatf("vec%0d", i), mk(vecs[i].sa, vecs[i].sa, 0, 0, 0, 0, 0),
                 mk(vecs[i].sb, vecs[i].sb, 0, 0, 0, 0, 0));
        end

        // a: mult, ready on BUSY cycle 16; b: div that times out, drains, then idles.
        fd_a = nop; fd_b = nop;
        for (int c = 0; c <= 20; c++) begin
            exp_t ea;
            exp_t eb;
            dx_a  = (c <= 17) ? mul : nop;
            rdy_a = (c == 17) || (c == 19);
            dx_b  = (c <= 9) ? dvd : nop;
            rdy_b = (c == 9);
            if (c == 0)       ea = mk(1, 0, 1, 0, 0, 0, 0);
            else if (c <= 16) ea = mk(1, 0, 0, 0, 1, 0, 0);
            else if (c == 17) ea = mk(0, 0, 0, 0, 1, 0, 1);
            else              ea = mk(0, 0, 0, 0, 0, 0, 0);
            if (c == 0)       eb = mk(1, 0, 0, 1, 0, 0, 0);
            else if (c <= 7)  eb = mk(1, 0, 0, 0, 1, 0, 0);
            else if (c == 8)  eb = mk(0, 0, 0, 0, 1, 0, 0);
            else              eb = mk(0, 0, 0, 0, 0, 1, 0);
            step($sformatf("md%0d", c), ea, eb);
        end
        rdy_a = 1'b0; rdy_b = 1'b0;
        chk("sat.b.stall_cycles", 32'(if_b.stall_cycles), 32'd15);
        chk("mult.a.md_ops", if_a.md_ops, 32'd1);

        // Clear coinciding with a stall, then counting resumes from zero.
        fd_a = enc_r(5'd7, 5'd5, 5'd3, 5'd0); dx_a = lw5;
        fd_b = fd_a; dx_b = lw5;
        clr_a = 1'b1; clr_b = 1'b1;
        step("clr0", mk(1, 1, 0, 0, 0, 0, 0), mk(1, 1, 0, 0, 0, 1, 0));
        clr_a = 1'b0; clr_b = 1'b0;
        step("clr1", mk(1, 1, 0, 0, 0, 0, 0), mk(1, 1, 0, 0, 0, 1, 0));
        fd_a = nop; dx_a = nop; fd_b = nop; dx_b = nop;
        step("clr2", mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 1, 0));
        chk("clr.b.stall_cycles", 32'(if_b.stall_cycles), 32'd1);

        // Reset asserted on BUSY cycle 5 of a mult in both instances.
        dx_a = mul; dx_b = mul;
        for (int c = 0; c <= 5; c++) begin
            if (c == 0) step("rst_s", mk(1, 0, 1, 0, 0, 0, 0), mk(1, 0, 1, 0, 0, 1, 0));
            else        step($sformatf("rst_b%0d", c), mk(1, 0, 0, 0, 1, 0, 0),
                             mk(1, 0, 0, 0, 1, 1, 0));
        end
        reset_n = 1'b0;
        dx_a = nop; dx_b = nop;
        step("rst_mid", mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        step("rst_post", mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));

        // a: ready on first BUSY cycle; b: ready coinciding with timeout.
        for (int c = 0; c <= 9; c++) begin
            exp_t ea;
            exp_t eb;
            dx_a  = (c <= 1) ? mul : nop;
            rdy_a = (c == 1);
            dx_b  = (c <= 8) ? dvd : nop;
            rdy_b = (c == 8);
            if (c == 0)      ea = mk(1, 0, 1, 0, 0, 0, 0);
            else if (c == 1) ea = mk(0, 0, 0, 0, 1, 0, 1);
            else             ea = mk(0, 0, 0, 0, 0, 0, 0);
            if (c == 0)      eb = mk(1, 0, 0, 1, 0, 0, 0);
            else if (c <= 7) eb = mk(1, 0, 0, 0, 1, 0, 0);
            else if (c == 8) eb = mk(0, 0, 0, 0, 1, 0, 1);
            else             eb = mk(0, 0, 0, 0, 0, 0, 0);
            step($sformatf("coin%0d", c), ea, eb);
        end
        chk("coin.b.md_ops", 32'(if_b.md_ops), 32'd1);
        chk("coin.b.md_error", 32'(if_b.md_error), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised pipeline hazard and stall controller for the 5-stage processor, sitting between the F/D and D/X pipeline latches. It detects load-use hazards with correct source decoding per opcode, and sequences the multi-cycle mult/div unit with an explicit start/busy/timeout state machine. It also keeps saturating performance counters for stall cycles and completed mult/div operations. Its `stall` output gates the PC, F/D, and D/X latch enables; the D/X latch inserts a nop when the hazard source is a load-use hazard.

## Interface
- `MD_TIMEOUT`, default 64: maximum cycles spent in BUSY before abort.
- `CNT_W`, default 32: width of the performance counters.
- `STORE_DATA_BYPASS`, default 1: if 1, a `sw` data-register match against an in-flight `lw` does not stall, because W→M bypass covers it.
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `fd_ir`  in  32  — instruction in F/D.
- `dx_ir`  in  32  — instruction in D/X.
- `md_ready`  in  1  — mult/div result valid. Sampled only in BUSY.
- `cnt_clear`  in  1  — synchronous clear of both counters.
- `stall`  out  1  — freeze PC, F/D, and D/X.
- `ld_bubble`  out  1  — D/X must load a nop this cycle (load-use hazard).
- `md_start_mult`, `md_start_div`  out  1  — one-cycle start pulses to the mult/div unit.
- `md_busy`  out  1  — state is BUSY.
- `md_error`  out  1  — sticky flag, set on timeout. Cleared only by reset.
- `stall_cycles`  out  CNT_W  — count of cycles with `stall`=1. Saturates.
- `md_ops`  out  CNT_W  — count of completed (non-timed-out) mult/div ops. Saturates.

## Operation
- Field decode:
  - opcode = [31:27]
  - rd = [26:22]
  - rs = [21:17]
  - rt = [16:12]
  - aluop = [6:2]
- Op identification:
  - R-type: opcode 00000.
  - mult: R-type with aluop 00110.
  - div: R-type with aluop 00111.
  - lw: opcode 01000.
  - sw: opcode 00111.
  - bne: opcode 00010.
  - blt: opcode 00110.
  - jr: opcode 00100.
- F/D source registers:
  - R-type reads rs and rt.
  - addi, lw, and sw read rs.
  - bne and blt read rd and rs.
  - jr reads rd.
  - sw additionally reads rd as data. When `STORE_DATA_BYPASS`=1 this rd read is excluded from hazard checks.
  - Register 0 never causes a hazard.
- Load-use hazard: `dx_ir` is lw, its rd ≠ 0, and rd equals any F/D source register. Result: `ld_bubble`=1 and `stall`=1.
- Mult/div FSM, states IDLE, BUSY, DRAIN.
  - IDLE:
    - If `dx_ir` is mult or div: pulse the matching `md_start_*`, assert `stall`, load timer with 1, go to BUSY.
    - Otherwise: stall only on load-use.
  - BUSY:
    - `md_busy`=1.
    - If `md_ready`=1: `stall`=0 this cycle so the op leaves D/X at the edge; `md_ops`++; go to IDLE.
    - Else, if timer = MD_TIMEOUT: set `md_error`, `stall`=0, go to DRAIN.
    - Else: `stall`=1 and timer++.
  - DRAIN: lasts one cycle. `stall`=0, no start is issued even if D/X still decodes as mult/div, then go to IDLE.
- `stall` = load-use hazard OR (IDLE and mult/div start) OR (BUSY and not ready and not timeout).
- Counters:
  - Increment by 1 per qualifying cycle and hold at all-ones.
  - `cnt_clear` has priority over increment.

## Timing
- Reset values:
  - state = IDLE
  - timer = 0
  - `md_error` = 0
  - `stall_cycles` = 0
  - `md_ops` = 0
  - all start pulses = 0
- All hazard and stall outputs are combinational from inputs and state. No added latency.
- The start pulse is asserted in the first cycle the op is in D/X, for exactly one cycle.
- `md_ready` is ignored in IDLE and DRAIN.
- If `md_ready` and timeout coincide, `md_ready` wins: no error is raised.
- Mult/div op with ready at BUSY cycle k: the total stall is k+1 cycles, counting the start cycle.
- A load-use hazard cannot coincide with a mult/div in D/X, because D/X holds exactly one instruction.
- `reset_n` asserted mid-BUSY: immediately returns to IDLE and drops `stall`. The mult/div unit is reset by the same signal.
- `cnt_clear` in the same cycle as a stall: the counter reads 0 next cycle, not 1.

## Structure
- Shared package `proc_isa_pkg` holds:
  - Opcode constants: R, LW, SW, BNE, BLT, JR, ADDI.
  - aluop constants: MULT, DIV.
  - Field bit positions.
  - The FSM state enum.
- One sub-module, `src_reg_decode`: takes an instruction and returns source valid bits plus addresses (`src_a`, `src_b`, `src_d`).

## Test plan
- D/X `lw $5,0($2)`, F/D `add $7,$5,$3` → `stall`=1 and `ld_bubble`=1 for one cycle. The same case with $0 as destination → no stall.
- D/X `lw $5`, F/D `sw $5,0($4)`:
  - `STORE_DATA_BYPASS`=1 → no stall.
  - `STORE_DATA_BYPASS`=0 → stall.
  - F/D `sw $6,0($5)` → stall in both cases.
- D/X mult, `md_ready` at BUSY cycle 16 → `md_start_mult` high for 1 cycle, `stall` high for 17 cycles, `md_ops`=1, return to IDLE.
- D/X div with no `md_ready`, `MD_TIMEOUT`=8 → `md_error` set after 8 BUSY cycles, one DRAIN cycle with no restart, then IDLE.
- `reset_n` low at BUSY cycle 5 → `stall`=0 and `md_busy`=0 immediately; counters read 0.
- Counter saturation with `CNT_W`=4 → `stall_cycles` holds at 15; a `cnt_clear` pulse → 0.
